key_event: RTL

//  Consumes the debounced, synchronised key level from the key synchroniser and classifies it into

---
 rtl/key_event.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_event.sv
// Classifies a debounced, synchronised key level into single-cycle event pulses:
// press, release, short click, double click, long press and auto-repeat.
module key_event #(
    parameter int CLK_FRE    = 50,
    parameter int KEY_ACTIVE = 1,
    parameter int LONG_MS    = 1000,
    parameter int DCLICK_MS  = 300,
    parameter int REPEAT_MS  = 200
) (
    input  logic i_sys_clk,
    input  logic i_rst_n,
    input  logic i_key_sync,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int TICK_CYC = CLK_FRE * 1000;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_CYC - 1);
    localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
    localparam logic [15:0]   DCLICK_LAST = 16'(DCLICK_MS - 1);
    localparam logic [15:0]   REPEAT_LAST = 16'(REPEAT_MS - 1);
    localparam logic          ACT_LVL     = (KEY_ACTIVE != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          key_now;
    logic          key_d;
    logic          pe;
    logic          ne;
    logic [PW-1:0] prescaler;
    logic [15:0]   ms_cnt;
    logic          tick;
    logic          long_hit;
    logic          dclick_hit;
    logic          repeat_hit;
    logic          timer_clr;
    logic          short_nxt;
    logic          double_nxt;
    logic          long_nxt;
    logic          repeat_nxt;

    assign key_now = (i_key_sync == ACT_LVL);
    assign pe      = key_now & ~key_d;
    assign ne      = ~key_now & key_d;
    assign o_held  = key_d;

    // A *_hit is true in the cycle whose edge makes ms_cnt reach the threshold,
    // so the timeout lands exactly N ms of cycles after the timer was cleared.
    assign tick       = (prescaler == PRE_LAST);
    assign long_hit   = tick && (ms_cnt == LONG_LAST);
    assign dclick_hit = tick && (ms_cnt == DCLICK_LAST);
    assign repeat_hit = tick && (ms_cnt == REPEAT_LAST);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Key edges take priority over timeouts in every state.
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pe) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (ne)            state_nxt = ST_WAIT2;
                else if (long_hit) state_nxt = ST_LONG;
            end
            ST_WAIT2: begin
                if (pe)              state_nxt = ST_PRESS2;
                else if (dclick_hit) state_nxt = ST_IDLE;
            end
            ST_PRESS2: begin
                if (ne)            state_nxt = ST_IDLE;
                else if (long_hit) state_nxt = ST_LONG;
            end
            ST_LONG: begin
                if (ne)              state_nxt = ST_IDLE;
                else if (repeat_hit) timer_clr = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) timer_clr = 1'b1;
    end

    always_comb begin
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            ST_PRESS1: long_nxt   = ~ne & long_hit;
            ST_WAIT2:  short_nxt  = ~pe & dclick_hit;
            ST_PRESS2: begin
                double_nxt = ne;
                long_nxt   = ~ne & long_hit;
            end
            ST_LONG:   repeat_nxt = ~ne & repeat_hit;
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            key_d     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_short   <= 1'b0;
            o_double  <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
        end else begin
            key_d     <= key_now;
            o_press   <= pe;
            o_release <= ne;
            o_short   <= short_nxt;
            o_double  <= double_nxt;
            o_long    <= long_nxt;
            o_repeat  <= repeat_nxt;
        end
    end

    // ms_cnt saturates so a long idle period never wraps back into a threshold.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            prescaler <= '0;
            ms_cnt    <= '0;
        end else if (timer_clr) begin
            prescaler <= '0;
            ms_cnt    <= '0;
        end else if (tick) begin
            prescaler <= '0;
            if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule
